spec_rat_nw: RTL and testbench

- Parametrised speculative register alias table for an N-wide rename stage, with an internal architectural RAT and a built-in recovery FSM (IDLE / RESTORE / WALK).
- Serves RENAME_WIDTH rename slots per cycle, with full intra-group bypass for every younger slot.
- Takes COMMIT_WIDTH commits per cycle into the arch table.
- On a flush, restores the spec table from the arch table, then replays ROB walk entries until the ROB signals walk_done.

---
 rtl/spec_rat_nw.sv | 145 ++++++++++++++
 tb/tb_spec_rat_nw.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spec_rat_nw.sv
// Speculative register alias table for an N-wide rename stage, backed by an
// architectural RAT, with flush recovery: restore from arch, then replay ROB walk beats.

module spec_rat_nw #(
    parameter int RENAME_WIDTH   = 2,
    parameter int COMMIT_WIDTH   = 2,
    parameter int NUM_LREG       = 32,
    parameter int NUM_PREG       = 64,
    parameter int LREG_W         = 5,
    parameter int PREG_W         = 6,
    parameter int ZERO_HARDWIRED = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush_valid,
    input  logic                           walk_done,
    output logic                           rename_ready,
    input  logic [RENAME_WIDTH-1:0]        rn_lrd_wren,
    input  logic [RENAME_WIDTH*LREG_W-1:0] rn_lrd,
    input  logic [RENAME_WIDTH*PREG_W-1:0] rn_prd_new,
    input  logic [RENAME_WIDTH-1:0]        rn_lrs1_rden,
    input  logic [RENAME_WIDTH-1:0]        rn_lrs2_rden,
    input  logic [RENAME_WIDTH-1:0]        rn_lrd_rden,
    input  logic [RENAME_WIDTH*LREG_W-1:0] rn_lrs1,
    input  logic [RENAME_WIDTH*LREG_W-1:0] rn_lrs2,
    output logic [RENAME_WIDTH*PREG_W-1:0] rn_prs1,
    output logic [RENAME_WIDTH*PREG_W-1:0] rn_prs2,
    output logic [RENAME_WIDTH*PREG_W-1:0] rn_prd_old,
    input  logic [COMMIT_WIDTH-1:0]        commit_valid,
    input  logic [COMMIT_WIDTH-1:0]        commit_need_wb,
    input  logic [COMMIT_WIDTH*LREG_W-1:0] commit_lrd,
    input  logic [COMMIT_WIDTH*PREG_W-1:0] commit_prd,
    input  logic [COMMIT_WIDTH-1:0]        walk_valid,
    input  logic [COMMIT_WIDTH*LREG_W-1:0] walk_lrd,
    input  logic [COMMIT_WIDTH*PREG_W-1:0] walk_prd,
    output logic [NUM_LREG*PREG_W-1:0]     arch_map,
    output logic [1:0]                     state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTORE = 2'd1,
        WALK    = 2'd2
    } state_t;

    state_t cur, nxt;
    logic [NUM_LREG-1:0][PREG_W-1:0] spec_q, spec_d, arch_q, arch_d;

    if (NUM_PREG > (1 << PREG_W) || NUM_LREG > (1 << LREG_W)) begin : g_bad_width
        $error("spec_rat_nw: index width too narrow for table size");
    end

    // Out-of-range and hardwired-zero destinations never update a table.
    function automatic logic writable(input logic [LREG_W-1:0] a);
        return (int'(a) < NUM_LREG) && !(ZERO_HARDWIRED != 0 && a == '0);
    endfunction

    assign rename_ready = (cur == IDLE) && !flush_valid;
    assign arch_map     = arch_q;
    assign state        = cur;

    always_comb begin
        arch_d = arch_q;
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            if (commit_valid[c] && commit_need_wb[c] && writable(commit_lrd[c*LREG_W +: LREG_W]))
                arch_d[commit_lrd[c*LREG_W +: LREG_W]] = commit_prd[c*PREG_W +: PREG_W];
        end
    end

    // Ascending slot order makes the youngest slot win on address collisions.
    always_comb begin
        nxt    = cur;
        spec_d = spec_q;
        case (cur)
            IDLE: begin
                if (flush_valid) begin
                    nxt = RESTORE;
                end else begin
                    for (int k = 0; k < RENAME_WIDTH; k++) begin
                        if (rn_lrd_wren[k] && writable(rn_lrd[k*LREG_W +: LREG_W]))
                            spec_d[rn_lrd[k*LREG_W +: LREG_W]] = rn_prd_new[k*PREG_W +: PREG_W];
                    end
                end
            end
            RESTORE: begin
                spec_d = arch_d;
                nxt    = flush_valid ? RESTORE : WALK;
            end
            WALK: begin
                if (flush_valid) begin
                    nxt = RESTORE;
                end else begin
                    for (int c = 0; c < COMMIT_WIDTH; c++) begin
                        if (walk_valid[c] && writable(walk_lrd[c*LREG_W +: LREG_W]))
                            spec_d[walk_lrd[c*LREG_W +: LREG_W]] = walk_prd[c*PREG_W +: PREG_W];
                    end
                    if (walk_done) nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur <= IDLE;
            for (int i = 0; i < NUM_LREG; i++) begin
                spec_q[i] <= PREG_W'(i);
                arch_q[i] <= PREG_W'(i);
            end
        end else begin
            cur    <= nxt;
            spec_q <= spec_d;
            arch_q <= arch_d;
        end
    end

    // Per-slot lookups; field 0 = lrs1, 1 = lrs2, 2 = lrd (old mapping).
    for (genvar k = 0; k < RENAME_WIDTH; k++) begin : g_slot
        logic [2:0][LREG_W-1:0] addr;
        logic [2:0]             en;
        logic [2:0][PREG_W-1:0] val;

        assign addr = {rn_lrd[k*LREG_W +: LREG_W], rn_lrs2[k*LREG_W +: LREG_W],
                       rn_lrs1[k*LREG_W +: LREG_W]};
        assign en   = {rn_lrd_rden[k], rn_lrs2_rden[k], rn_lrs1_rden[k]};

        always_comb begin
            val = '0;
            for (int f = 0; f < 3; f++) begin
                if (int'(addr[f]) < NUM_LREG) val[f] = spec_q[addr[f]];
                for (int j = 0; j < k; j++) begin
                    if (rn_lrd_wren[j] && rn_lrd[j*LREG_W +: LREG_W] == addr[f])
                        val[f] = rn_prd_new[j*PREG_W +: PREG_W];
                end
                if (!en[f] || (ZERO_HARDWIRED != 0 && addr[f] == '0)) val[f] = '0;
            end
        end

        assign rn_prs1[k*PREG_W +: PREG_W]    = val[0];
        assign rn_prs2[k*PREG_W +: PREG_W]    = val[1];
        assign rn_prd_old[k*PREG_W +: PREG_W] = val[2];
    end

endmodule

// File: tb/tb_spec_rat_nw.sv
// Bench for spec_rat_nw: directed recovery scenarios followed by random traffic,
// compared against an array-based reference of the alias tables.

module tb_spec_rat_nw;
    localparam int RW = 4, CW = 2, NL = 32, NP = 64, LW = 5, PW = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush_valid, walk_done, rename_ready;
    logic [RW-1:0]    rn_lrd_wren, rn_lrs1_rden, rn_lrs2_rden, rn_lrd_rden;
    logic [RW*LW-1:0] rn_lrd, rn_lrs1, rn_lrs2;
    logic [RW*PW-1:0] rn_prd_new, rn_prs1, rn_prs2, rn_prd_old;
    logic [CW-1:0]    commit_valid, commit_need_wb, walk_valid;
    logic [CW*LW-1:0] commit_lrd, walk_lrd;
    logic [CW*PW-1:0] commit_prd, walk_prd;
    logic [NL*PW-1:0] arch_map;
    logic [1:0]       state;

    spec_rat_nw #(.RENAME_WIDTH(RW), .COMMIT_WIDTH(CW), .NUM_LREG(NL), .NUM_PREG(NP),
                  .LREG_W(LW), .PREG_W(PW), .ZERO_HARDWIRED(1)) dut (
        .clock(clock), .reset(reset), .flush_valid(flush_valid), .walk_done(walk_done),
        .rename_ready(rename_ready), .rn_lrd_wren(rn_lrd_wren), .rn_lrd(rn_lrd),
        .rn_prd_new(rn_prd_new), .rn_lrs1_rden(rn_lrs1_rden), .rn_lrs2_rden(rn_lrs2_rden),
        .rn_lrd_rden(rn_lrd_rden), .rn_lrs1(rn_lrs1), .rn_lrs2(rn_lrs2), .rn_prs1(rn_prs1),
        .rn_prs2(rn_prs2), .rn_prd_old(rn_prd_old), .commit_valid(commit_valid),
        .commit_need_wb(commit_need_wb), .commit_lrd(commit_lrd), .commit_prd(commit_prd),
        .walk_valid(walk_valid), .walk_lrd(walk_lrd), .walk_prd(walk_prd),
        .arch_map(arch_map), .state(state)
    );

    always #5 clock = ~clock;

    int errors = 0, checks = 0;
    int s_wren[RW], s_lrd[RW], s_prd[RW], s_r1en[RW], s_r1[RW], s_r2en[RW], s_r2[RW], s_rden[RW];
    int c_val[CW], c_wb[CW], c_lrd[CW], c_prd[CW], w_val[CW], w_lrd[CW], w_prd[CW];
    int flush_i, done_i;
    int spec_m[NL], arch_m[NL], mode;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        for (int k = 0; k < RW; k++) begin
            s_wren[k] = 0; s_lrd[k] = 0; s_prd[k] = 0; s_r1en[k] = 0; s_r1[k] = 0;
            s_r2en[k] = 0; s_r2[k] = 0; s_rden[k] = 0;
        end
        for (int c = 0; c < CW; c++) begin
            c_val[c] = 0; c_wb[c] = 0; c_lrd[c] = 0; c_prd[c] = 0;
            w_val[c] = 0; w_lrd[c] = 0; w_prd[c] = 0;
        end
        flush_i = 0; done_i = 0;
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < RW; k++) begin
            s_wren[k] = int'($urandom_range(0, 1));
            s_lrd[k]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NL-1)) : int'($urandom_range(0, 7));
            s_prd[k]  = int'($urandom_range(0, NP-1));
            s_r1en[k] = int'($urandom_range(0, 3) != 0);
            s_r1[k]   = int'($urandom_range(0, 7));
            s_r2en[k] = int'($urandom_range(0, 3) != 0);
            s_r2[k]   = int'($urandom_range(0, NL-1));
            s_rden[k] = int'($urandom_range(0, 1));
        end
        for (int c = 0; c < CW; c++) begin
            c_val[c] = int'($urandom_range(0, 1)); c_wb[c] = int'($urandom_range(0, 3) != 0);
            c_lrd[c] = int'($urandom_range(0, 7)); c_prd[c] = int'($urandom_range(0, NP-1));
            w_val[c] = int'($urandom_range(0, 1));
            w_lrd[c] = int'($urandom_range(0, 7)); w_prd[c] = int'($urandom_range(0, NP-1));
        end
        flush_i = int'($urandom_range(0, 9) == 0);
        done_i  = int'($urandom_range(0, 2) == 0);
    endtask

    task automatic apply();
        flush_valid = (flush_i != 0);
        walk_done   = (done_i != 0);
        for (int k = 0; k < RW; k++) begin
            rn_lrd_wren[k]  = (s_wren[k] != 0);
            rn_lrs1_rden[k] = (s_r1en[k] != 0);
            rn_lrs2_rden[k] = (s_r2en[k] != 0);
            rn_lrd_rden[k]  = (s_rden[k] != 0);
            rn_lrd[k*LW +: LW]     = LW'(s_lrd[k]);
            rn_lrs1[k*LW +: LW]    = LW'(s_r1[k]);
            rn_lrs2[k*LW +: LW]    = LW'(s_r2[k]);
            rn_prd_new[k*PW +: PW] = PW'(s_prd[k]);
        end
        for (int c = 0; c < CW; c++) begin
            commit_valid[c]   = (c_val[c] != 0);
            commit_need_wb[c] = (c_wb[c] != 0);
            walk_valid[c]     = (w_val[c] != 0);
            commit_lrd[c*LW +: LW] = LW'(c_lrd[c]);
            commit_prd[c*PW +: PW] = PW'(c_prd[c]);
            walk_lrd[c*LW +: LW]   = LW'(w_lrd[c]);
            walk_prd[c*PW +: PW]   = PW'(w_prd[c]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            spec_m[i] = i;
            arch_m[i] = i;
        end
        mode = 0;
    endtask

    // Nearest older slot writing the same register supplies the value.
    function automatic int exp_rd(input int k, input int addr, input int en);
        if (en == 0 || addr == 0) return 0;
        for (int j = k - 1; j >= 0; j--)
            if (s_wren[j] != 0 && s_lrd[j] == addr) return s_prd[j];
        return spec_m[addr];
    endfunction

    task automatic check_outputs();
        logic [NL*PW-1:0] am;
        for (int k = 0; k < RW; k++) begin
            chk($sformatf("prs1[%0d]", k), rn_prs1[k*PW +: PW], exp_rd(k, s_r1[k], s_r1en[k]));
            chk($sformatf("prs2[%0d]", k), rn_prs2[k*PW +: PW], exp_rd(k, s_r2[k], s_r2en[k]));
            chk($sformatf("prd_old[%0d]", k), rn_prd_old[k*PW +: PW], exp_rd(k, s_lrd[k], s_rden[k]));
        end
        chk("rename_ready", rename_ready, (mode == 0 && flush_i == 0));
        chk("state", state, mode);
        for (int i = 0; i < NL; i++) am[i*PW +: PW] = PW'(arch_m[i]);
        chk("arch_map", arch_map, am);
    endtask

    task automatic model_tick();
        int an[NL];
        an = arch_m;
        for (int c = 0; c < CW; c++)
            if (c_val[c] != 0 && c_wb[c] != 0 && c_lrd[c] != 0) an[c_lrd[c]] = c_prd[c];
        case (mode)
            0: begin
                if (flush_i != 0) mode = 1;
                else for (int k = 0; k < RW; k++)
                    if (s_wren[k] != 0 && s_lrd[k] != 0) spec_m[s_lrd[k]] = s_prd[k];
            end
            1: begin
                spec_m = an;
                mode = (flush_i != 0) ? 1 : 2;
            end
            default: begin
                if (flush_i != 0) mode = 1;
                else begin
                    for (int c = 0; c < CW; c++)
                        if (w_val[c] != 0 && w_lrd[c] != 0) spec_m[w_lrd[c]] = w_prd[c];
                    if (done_i != 0) mode = 0;
                end
            end
        endcase
        arch_m = an;
    endtask

    task automatic settle();
        apply();
        #1;
        check_outputs();
    endtask

    task automatic advance();
        model_tick();
        @(negedge clock);
    endtask

    initial begin
        clear(); model_reset(); apply();
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset mapping and read enable gating
        clear(); s_r1en[0] = 1; s_r1[0] = 7; s_r1[1] = 0;
        settle();
        chk("rst_prs1_s0", rn_prs1[0 +: PW], 7);
        chk("rden0_s1", rn_prs1[PW +: PW], 0);
        advance();

        // Intra-group bypass with two writers of the same register
        clear();
        s_wren[0] = 1; s_lrd[0] = 5; s_prd[0] = 40;
        s_wren[2] = 1; s_lrd[2] = 5; s_prd[2] = 41; s_rden[2] = 1;
        s_r2en[3] = 1; s_r2[3] = 5; s_r1en[1] = 1; s_r1[1] = 5;
        settle();
        chk("byp_s3", rn_prs2[3*PW +: PW], 41);
        chk("byp_s1", rn_prs1[PW +: PW], 40);
        chk("byp_old_s2", rn_prd_old[2*PW +: PW], 40);
        advance();
        clear(); s_r1en[0] = 1; s_r1[0] = 5;
        settle(); chk("spec5", rn_prs1[0 +: PW], 41); advance();

        // Hardwired zero
        clear(); s_wren[0] = 1; s_lrd[0] = 0; s_prd[0] = 50; s_r1en[1] = 1; s_r1[1] = 0;
        settle(); chk("zero_byp", rn_prs1[PW +: PW], 0); advance();

        // Same-cycle commits to one register, then flush restores from arch
        clear();
        c_val[0] = 1; c_wb[0] = 1; c_lrd[0] = 3; c_prd[0] = 33;
        c_val[1] = 1; c_wb[1] = 1; c_lrd[1] = 3; c_prd[1] = 34;
        s_wren[0] = 1; s_lrd[0] = 3; s_prd[0] = 45;
        settle(); advance();
        clear(); flush_i = 1; s_r1en[0] = 1; s_r1[0] = 3;
        s_wren[1] = 1; s_lrd[1] = 7; s_prd[1] = 61;
        settle();
        chk("arch3", arch_map[3*PW +: PW], 34);
        chk("spec3_pre", rn_prs1[0 +: PW], 45);
        chk("rdy_flush", rename_ready, 0);
        advance();
        clear(); s_wren[0] = 1; s_lrd[0] = 6; s_prd[0] = 60;
        settle(); chk("st_restore", state, 1); chk("rdy_restore", rename_ready, 0); advance();
        clear(); s_r1en[0] = 1; s_r1[0] = 3; done_i = 1;
        w_val[0] = 1; w_lrd[0] = 4; w_prd[0] = 44;
        w_val[1] = 1; w_lrd[1] = 4; w_prd[1] = 46;
        settle();
        chk("st_walk", state, 2); chk("restored3", rn_prs1[0 +: PW], 34); chk("rdy_walk", rename_ready, 0);
        advance();
        clear(); s_r1en[0] = 1; s_r1[0] = 4; s_r2en[0] = 1; s_r2[0] = 6; s_r1en[1] = 1; s_r1[1] = 7;
        settle();
        chk("walk4", rn_prs1[0 +: PW], 46); chk("ign6", rn_prs2[0 +: PW], 6);
        chk("ign7", rn_prs1[PW +: PW], 7);
        chk("st_idle", state, 0); chk("rdy_idle", rename_ready, 1);
        advance();

        // Flush during WALK drops the beat; reset mid-WALK
        clear(); flush_i = 1; settle(); advance();
        clear(); settle(); advance();
        clear(); flush_i = 1; w_val[0] = 1; w_lrd[0] = 8; w_prd[0] = 20;
        settle(); chk("st_walk2", state, 2); advance();
        clear(); settle(); chk("st_reflush", state, 1); advance();
        clear(); s_r1en[0] = 1; s_r1[0] = 8; w_val[0] = 1; w_lrd[0] = 9; w_prd[0] = 21;
        settle(); chk("drop8", rn_prs1[0 +: PW], 8); advance();
        clear(); s_r1en[0] = 1; s_r1[0] = 9; s_r2en[0] = 1; s_r2[0] = 4;
        apply(); #1;
        chk("pre_rst9", rn_prs1[0 +: PW], 21);
        reset = 1'b1; model_reset(); #1;
        check_outputs();
        chk("rst_st", state, 0); chk("rst9", rn_prs1[0 +: PW], 9); chk("rst4", rn_prs2[0 +: PW], 4);
        chk("rst_rdy", rename_ready, 1);
        @(negedge clock);
        reset = 1'b0;

        // Random traffic with occasional asynchronous resets
        for (int n = 0; n < 800; n++) begin
            randomize_inputs();
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1; model_reset();
                settle();
                @(negedge clock);
                reset = 1'b0;
            end else begin
                settle();
                advance();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
